// File: rtl/spi_master_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_seq_ctrl
// Description : Single-transfer sequencer for the SPI master padframe.
//               Accepts one command (mode, length, divider, TX word) and
//               drives padmode, CSN, SCK and SDO0..3 in SPI mode 0
//               (CPOL=0, CPHA=0), MSB first. SDI0..3 are sampled into a
//               right-aligned RX word that is returned with a done pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i                  system clock
//   rst_ni                 asynchronous reset, active low
//   start_i                command strobe, accepted only while idle
//   mode_i[1:0]            00 STD, 01 QUAD_TX, 10 QUAD_RX, 11 handled as STD
//   len_i                  number of SCK cycles minus 1
//   clkdiv_i               SCK half-period minus 1, in clk cycles
//   tx_data_i              TX word, MSB sent first
//   busy_o                 transfer in progress (cycle after accept .. done)
//   done_o                 one-cycle completion pulse
//   rx_data_o              received word, held until the next accepted start
//   padmode_spi_master_o   padframe mode select
//   spi_master_csn_o       chip select, active low
//   spi_master_sck_o       serial clock
//   spi_master_sdo0..3_o   serial data out
//   spi_master_sdi0..3_i   serial data in
// ============================================================================
module spi_master_seq_ctrl #(
  parameter int DATA_W    = 32,
  parameter int CLK_DIV_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [1:0]                mode_i,
  input  logic [$clog2(DATA_W)-1:0] len_i,
  input  logic [CLK_DIV_W-1:0]      clkdiv_i,
  input  logic [DATA_W-1:0]         tx_data_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [DATA_W-1:0]         rx_data_o,
  output logic [1:0]                padmode_spi_master_o,
  output logic                      spi_master_csn_o,
  output logic                      spi_master_sck_o,
  output logic                      spi_master_sdo0_o,
  output logic                      spi_master_sdo1_o,
  output logic                      spi_master_sdo2_o,
  output logic                      spi_master_sdo3_o,
  input  logic                      spi_master_sdi0_i,
  input  logic                      spi_master_sdi1_i,
  input  logic                      spi_master_sdi2_i,
  input  logic                      spi_master_sdi3_i
);

  localparam int c_len_w = $clog2(DATA_W);

  // Longest quad transfer: one nibble per SCK cycle fills the word.
  localparam logic [c_len_w-1:0] c_quad_max = c_len_w'(DATA_W / 4 - 1);

  localparam logic [1:0] c_mode_std     = 2'b00;
  localparam logic [1:0] c_mode_quad_tx = 2'b01;
  localparam logic [1:0] c_mode_quad_rx = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]           r_mode;
  logic [c_len_w-1:0]   r_len;
  logic [CLK_DIV_W-1:0] r_div;
  logic [CLK_DIV_W-1:0] r_div_cnt;
  logic [c_len_w-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]    r_tx;
  logic [DATA_W-1:0]    r_rx;
  logic                 r_sck;

  logic               w_accept;
  logic               w_tick;
  logic               w_sck_rise;
  logic               w_sck_fall;
  logic [1:0]         w_mode_eff;
  logic               w_quad_cmd;
  logic [c_len_w-1:0] w_len_eff;
  logic               w_active;
  logic               w_drive;

  // Command decode: mode 11 is folded into STD at latch time so the rest of
  // the datapath only ever sees the three legal modes.
  assign w_mode_eff = (mode_i == 2'b11) ? c_mode_std : mode_i;
  assign w_quad_cmd = (w_mode_eff != c_mode_std);
  assign w_len_eff  = (w_quad_cmd && (len_i > c_quad_max)) ? c_quad_max : len_i;

  // One half-period of SCK has elapsed when the divider count reaches clkdiv.
  assign w_tick = (r_div_cnt == r_div);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and per-cycle strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sck_rise   = 1'b0;
    w_sck_fall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept     = 1'b1;
          w_state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_tick) begin
          w_state_next = S_XFER;
        end
      end
      S_XFER: begin
        if (w_tick) begin
          if (!r_sck) begin
            w_sck_rise = 1'b1;
          end else begin
            w_sck_fall = 1'b1;
            // The falling edge that completes the last SCK cycle ends XFER.
            if (r_bit_cnt == r_len) begin
              w_state_next = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: command latch, divider, bit counter, shift registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode    <= c_mode_std;
      r_len     <= '0;
      r_div     <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_sck     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode    <= w_mode_eff;
        r_len     <= w_len_eff;
        r_div     <= clkdiv_i;
        r_tx      <= tx_data_i;
        r_rx      <= '0;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_sck     <= 1'b0;
      end else if (w_active) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      end

      if (w_sck_rise) begin
        r_sck <= 1'b1;
        case (r_mode)
          c_mode_quad_rx: r_rx <= {r_rx[DATA_W-5:0], spi_master_sdi3_i, spi_master_sdi2_i,
                                   spi_master_sdi1_i, spi_master_sdi0_i};
          c_mode_quad_tx: r_rx <= r_rx;
          default:        r_rx <= {r_rx[DATA_W-2:0], spi_master_sdi0_i};
        endcase
      end

      if (w_sck_fall) begin
        r_sck     <= 1'b0;
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_mode == c_mode_std) begin
          r_tx <= {r_tx[DATA_W-2:0], 1'b0};
        end else begin
          r_tx <= {r_tx[DATA_W-5:0], 4'b0000};
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // CSN is low for SETUP, XFER and HOLD; padmode follows the latched mode for
  // exactly that window so it never changes while the slave is selected.
  assign w_active = (r_state == S_SETUP) || (r_state == S_XFER) || (r_state == S_HOLD);
  assign w_drive  = (r_state == S_SETUP) || (r_state == S_XFER);

  assign busy_o               = (r_state != S_IDLE);
  assign done_o               = (r_state == S_DONE);
  assign rx_data_o            = r_rx;
  assign padmode_spi_master_o = w_active ? r_mode : 2'b00;
  assign spi_master_csn_o     = ~w_active;
  assign spi_master_sck_o     = r_sck;

  always_comb begin
    spi_master_sdo0_o = 1'b0;
    spi_master_sdo1_o = 1'b0;
    spi_master_sdo2_o = 1'b0;
    spi_master_sdo3_o = 1'b0;
    if (w_drive) begin
      case (r_mode)
        c_mode_std: begin
          spi_master_sdo0_o = r_tx[DATA_W-1];
        end
        c_mode_quad_tx: begin
          spi_master_sdo3_o = r_tx[DATA_W-1];
          spi_master_sdo2_o = r_tx[DATA_W-2];
          spi_master_sdo1_o = r_tx[DATA_W-3];
          spi_master_sdo0_o = r_tx[DATA_W-4];
        end
        default: begin
          spi_master_sdo0_o = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
